// File: rtl/pfram_arbiter.sv
// Playfield RAM arbiter: shares one single-port RAM between the latched 6502 bus port
// and the video tile-fetch port, and routes read data back to whichever port issued it.
module pfram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_strobe,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_ovr,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_rvalid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {NONE, CPU, VID} slot_t;

    slot_t              last;
    logic               cpu_pend;
    logic               cpu_we_q;
    logic [ADDR_W-1:0]  cpu_addr_q;
    logic [DATA_W-1:0]  cpu_wdata_q;
    logic [DATA_W-1:0]  vid_rdata_q;
    logic               issue_cpu;
    logic               issue_vid;
    logic [RD_LAT-1:0]  vld_p;
    logic [RD_LAT-1:0]  cpu_p;
    logic [RD_LAT-1:0]  we_p;

    // Issue stage: the CPU yields only to a waiting video request right after its own slot.
    always_comb begin
        issue_cpu = !reset && cpu_pend && !(last == CPU && vid_req);
        issue_vid = !reset && !issue_cpu && vid_req;
        ram_en    = issue_cpu || issue_vid;
        ram_we    = issue_cpu && cpu_we_q;
        ram_addr  = '0;
        ram_wdata = '0;
        if (issue_cpu) begin
            ram_addr  = cpu_addr_q;
            ram_wdata = cpu_wdata_q;
        end else if (issue_vid) begin
            ram_addr  = vid_addr;
        end
    end

    assign vid_gnt = issue_vid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last     <= NONE;
            cpu_pend <= 1'b0;
            cpu_ovr  <= 1'b0;
        end else begin
            if (issue_cpu)      last <= CPU;
            else if (issue_vid) last <= VID;
            else                last <= NONE;

            if (cpu_strobe && !cpu_pend) cpu_pend <= 1'b1;
            else if (issue_cpu)          cpu_pend <= 1'b0;

            if (cpu_strobe && cpu_pend) cpu_ovr <= 1'b1;
        end
    end

    // The captured request is pure data; cpu_pend alone says whether it is meaningful.
    always_ff @(posedge clk) begin
        if (cpu_strobe && !cpu_pend) begin
            cpu_we_q    <= cpu_we;
            cpu_addr_q  <= cpu_addr;
            cpu_wdata_q <= cpu_wdata;
        end
    end

    // Tag pipeline: stage RD_LAT-1 lines up with ram_rdata for the access it describes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p <= '0;
            cpu_p <= '0;
            we_p  <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                vld_p[i] <= vld_p[i-1];
                cpu_p[i] <= cpu_p[i-1];
                we_p[i]  <= we_p[i-1];
            end
            vld_p[0] <= ram_en;
            cpu_p[0] <= issue_cpu;
            we_p[0]  <= ram_we;
        end
    end

    // Completion stage
    assign cpu_done   = vld_p[RD_LAT-1] && cpu_p[RD_LAT-1];
    assign vid_rvalid = vld_p[RD_LAT-1] && !cpu_p[RD_LAT-1];
    assign vid_rdata  = vid_rvalid ? ram_rdata : vid_rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_rdata   <= '0;
            vid_rdata_q <= '0;
        end else begin
            if (cpu_done && !we_p[RD_LAT-1]) cpu_rdata <= ram_rdata;
            if (vid_rvalid)                  vid_rdata_q <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_pfram_arbiter.sv
// Directed bench for pfram_arbiter with RD_LAT=2 and a behavioural two-stage RAM;
// unwritten RAM locations read back as addr[7:0]^8'hA5.
module tb_pfram_arbiter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_strobe;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_done;
    logic              cpu_ovr;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_gnt;
    logic [DATA_W-1:0] vid_rdata;
    logic              vid_rvalid;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pfram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .cpu_strobe(cpu_strobe), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_ovr(cpu_ovr),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    function automatic logic [7:0] pat(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    bit [DATA_W-1:0] mem [1024];
    bit              wr  [1024];
    logic [DATA_W-1:0] rd_p0 = '0;
    logic [DATA_W-1:0] rd_p1 = '0;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                wr[ram_addr]  <= 1'b1;
            end
            rd_p0 <= wr[ram_addr] ? mem[ram_addr] : pat(ram_addr);
        end
        rd_p1 <= rd_p0;
    end
    assign ram_rdata = rd_p1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ram_en"},     32'(ram_en),     32'(0));
        chk({tag, "_vid_gnt"},    32'(vid_gnt),    32'(0));
        chk({tag, "_cpu_done"},   32'(cpu_done),   32'(0));
        chk({tag, "_cpu_ovr"},    32'(cpu_ovr),    32'(0));
        chk({tag, "_vid_rvalid"}, 32'(vid_rvalid), 32'(0));
        chk({tag, "_cpu_rdata"},  32'(cpu_rdata),  32'(0));
        chk({tag, "_vid_rdata"},  32'(vid_rdata),  32'(0));
    endtask

    initial begin
        logic [ADDR_W-1:0] vaddr;
        int done_cnt;
        reset = 1'b1; cpu_strobe = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        vid_req = 1'b0; vid_addr = '0;

        // Reset values, reset gating of a pending video request, reset mid-burst
        mid;
        chk_idle("rst_init");
        nxt; vid_req = 1'b1; vid_addr = 10'h005;
        mid;
        chk("rst_hold_gnt", 32'(vid_gnt), 32'(0));
        chk("rst_hold_en",  32'(ram_en),  32'(0));
        nxt; reset = 1'b0;
        mid;
        chk("burst_gnt0",  32'(vid_gnt),  32'(1));
        chk("burst_addr0", 32'(ram_addr), 32'(10'h005));
        nxt; vid_addr = 10'h006;
        mid;
        chk("burst_gnt1", 32'(vid_gnt), 32'(1));
        reset = 1'b1;
        #1;
        chk("rst_mid_en",  32'(ram_en),  32'(0));
        chk("rst_mid_gnt", 32'(vid_gnt), 32'(0));
        nxt; vid_req = 1'b0;
        mid;
        chk_idle("rst_mid");
        nxt; reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mid;
            chk("rst_no_rvalid", 32'(vid_rvalid), 32'(0));
            chk("rst_no_done",   32'(cpu_done),   32'(0));
            nxt;
        end

        // CPU write 0x5C to 0x3A5, then read it back
        cpu_strobe = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3A5; cpu_wdata = 8'h5C;
        mid;
        chk("wr_strobe_en", 32'(ram_en), 32'(0));
        nxt; cpu_strobe = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mid;
        chk("wr_issue_en",    32'(ram_en),    32'(1));
        chk("wr_issue_we",    32'(ram_we),    32'(1));
        chk("wr_issue_addr",  32'(ram_addr),  32'(10'h3A5));
        chk("wr_issue_wdata", 32'(ram_wdata), 32'(8'h5C));
        chk("wr_done_early",  32'(cpu_done),  32'(0));
        nxt; mid;
        chk("wr_done_early2", 32'(cpu_done), 32'(0));
        nxt; mid;
        chk("wr_done", 32'(cpu_done), 32'(1));
        nxt; mid;
        chk("wr_done_pulse",   32'(cpu_done),  32'(0));
        chk("wr_rdata_untouched", 32'(cpu_rdata), 32'(0));
        nxt; cpu_strobe = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3A5;
        mid;
        nxt; cpu_strobe = 1'b0; cpu_addr = '0;
        mid;
        chk("rd_issue_en",   32'(ram_en),   32'(1));
        chk("rd_issue_we",   32'(ram_we),   32'(0));
        chk("rd_issue_addr", 32'(ram_addr), 32'(10'h3A5));
        nxt; mid;
        nxt; mid;
        chk("rd_done", 32'(cpu_done), 32'(1));
        nxt; mid;
        chk("rd_rdata",      32'(cpu_rdata), 32'(8'h5C));
        chk("rd_done_pulse", 32'(cpu_done),  32'(0));
        nxt;

        // Contention: continuous video with one CPU read of 0x020 strobed at i=3
        vaddr = 10'h100;
        for (int i = 0; i < 10; i++) begin
            cpu_strobe = (i == 3); cpu_we = 1'b0; cpu_addr = 10'h020;
            vid_req = 1'b1; vid_addr = vaddr;
            mid;
            chk("cont_gnt", 32'(vid_gnt), 32'(i != 4));
            if (i == 4) chk("cont_cpu_addr", 32'(ram_addr), 32'(10'h020));
            else        chk("cont_vid_addr", 32'(ram_addr), 32'(vaddr));
            chk("cont_done", 32'(cpu_done), 32'(i == 6));
            if (i == 7) chk("cont_rdata", 32'(cpu_rdata), 32'(8'h85));
            if (i != 4) vaddr = vaddr + 10'd1;
            nxt;
        end
        cpu_strobe = 1'b0; vid_req = 1'b0;
        repeat (3) nxt;

        // Video stream: 16 back-to-back reads from 0x200
        for (int i = 0; i < 20; i++) begin
            vid_req = (i < 16);
            vid_addr = 10'(10'h200 + i);
            mid;
            chk("strm_gnt",    32'(vid_gnt),    32'(i < 16));
            chk("strm_rvalid", 32'(vid_rvalid), 32'(i >= 2 && i < 18));
            if (i >= 2 && i < 18)
                chk("strm_rdata", 32'(vid_rdata), 32'(8'((i - 2) ^ 8'hA5)));
            nxt;
        end
        vid_req = 1'b0;
        mid;
        chk("strm_rdata_hold", 32'(vid_rdata), 32'(8'hAA));
        nxt;

        // Tag routing: video 0x011, CPU read 0x010, video 0x012
        cpu_strobe = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
        vid_req = 1'b1; vid_addr = 10'h011;
        mid;
        chk("tag_gnt0",  32'(vid_gnt),  32'(1));
        chk("tag_addr0", 32'(ram_addr), 32'(10'h011));
        nxt; cpu_strobe = 1'b0; vid_addr = 10'h012;
        mid;
        chk("tag_cpu_gnt",  32'(vid_gnt),  32'(0));
        chk("tag_cpu_addr", 32'(ram_addr), 32'(10'h010));
        nxt;
        mid;
        chk("tag_addr1",   32'(ram_addr),   32'(10'h012));
        chk("tag_rvalid0", 32'(vid_rvalid), 32'(1));
        chk("tag_vdata0",  32'(vid_rdata),  32'(8'hB4));
        chk("tag_done0",   32'(cpu_done),   32'(0));
        nxt; vid_req = 1'b0;
        mid;
        chk("tag_rvalid_cpu", 32'(vid_rvalid), 32'(0));
        chk("tag_done_cpu",   32'(cpu_done),   32'(1));
        chk("tag_vdata_hold", 32'(vid_rdata),  32'(8'hB4));
        nxt;
        mid;
        chk("tag_rvalid1", 32'(vid_rvalid), 32'(1));
        chk("tag_vdata1",  32'(vid_rdata),  32'(8'hB7));
        chk("tag_cdata",   32'(cpu_rdata),  32'(8'hB5));
        chk("tag_done1",   32'(cpu_done),   32'(0));
        nxt;
        mid;
        chk("tag_cdata_hold", 32'(cpu_rdata), 32'(8'hB5));
        nxt;

        // Overrun: second strobe while the first is still pending
        cpu_strobe = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h050; cpu_wdata = 8'h11;
        vid_req = 1'b1; vid_addr = 10'h300;
        mid;
        chk("ovr_before", 32'(cpu_ovr), 32'(0));
        chk("ovr_gnt0",   32'(vid_gnt), 32'(1));
        nxt; cpu_addr = 10'h051; cpu_wdata = 8'h22;
        mid;
        chk("ovr_issue_we",    32'(ram_we),    32'(1));
        chk("ovr_issue_addr",  32'(ram_addr),  32'(10'h050));
        chk("ovr_issue_wdata", 32'(ram_wdata), 32'(8'h11));
        nxt; cpu_strobe = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            mid;
            chk("ovr_sticky",  32'(cpu_ovr), 32'(1));
            chk("ovr_no_2nd",  32'(ram_we),  32'(0));
            chk("ovr_vid_gnt", 32'(vid_gnt), 32'(1));
            if (cpu_done) done_cnt++;
            nxt;
        end
        chk("ovr_done_count", 32'(done_cnt), 32'(1));
        vid_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
